// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Latency/backpressure: n/a (declarations only).
package rf_ctrl_pkg;

  localparam int RF_DEPTH = 8;
  localparam int RF_AW    = 3;
  localparam int RF_DW    = 16;
  localparam int CLR_LAST = RF_DEPTH - 1;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester, clear-control and register-file write bus of the write arbiter.
// Latency/backpressure: n/a (wiring only); req_ready is the per-requester accept.
interface rf_write_arbiter_if
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               clr_start;
  logic               clr_busy;
  logic               clr_done;
  logic               rf_wr;
  logic [0:AW-1]      rf_wr_addr;
  logic [0:DW-1]      rf_d_in;
  logic [2:0]         grant_id;

  modport master (
    output req_valid, req_addr, req_data, clr_start,
    input  req_ready, clr_busy, clr_done, rf_wr, rf_wr_addr, rf_d_in, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_start,
    output req_ready, clr_busy, clr_done, rf_wr, rf_wr_addr, rf_d_in, grant_id
  );

endinterface

// File: rtl/rf_write_arbiter_rr_arb.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping mod N.
// Latency 0; no state, the pointer is owned by the caller.
module rr_arb #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the register-file write port, plus an 8-write zeroing sequence.
// Latency 1 cycle accept-to-rf_wr; req_ready drops to zero while clearing or on clr_start.
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic               clk,
  input  logic               reset,
  rf_write_arbiter_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [2:0]      gid_q, gid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            any_gnt;
  logic [NREQ-1:0] ready;

  rr_arb #(.N(NREQ)) u_rr_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_gnt)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    gid_d   = gid_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ready   = '0;
    unique case (state_q)
      ARB: begin
        if (bus.clr_start) begin
          // Clear pre-empts arbitration; pending requests simply wait.
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (any_gnt) begin
          ready  = gnt;
          wr_d   = 1'b1;
          addr_d = bus.req_addr[int'(gnt_idx)*AW +: AW];
          data_d = bus.req_data[int'(gnt_idx)*DW +: DW];
          gid_d  = 3'(gnt_idx);
          ptr_d  = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
      end
      CLEAR: begin
        wr_d   = 1'b1;
        addr_d = cnt_q;
        data_d = '0;
        busy_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == AW'(CLR_LAST)) begin
          state_d = ARB;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.rf_wr      = wr_q;
  assign bus.rf_wr_addr = addr_q;
  assign bus.rf_d_in    = data_q;
  assign bus.grant_id   = gid_q;
  assign bus.clr_busy   = busy_q;
  assign bus.clr_done   = done_q;

endmodule
